// File: rtl/hazard_control_unit_if.sv
// Hazard control bundle between the pipeline datapath and the hazard control unit.
// master = pipeline side (drives hazard inputs), slave = hazard control unit.
interface hazard_control_unit_if;
    logic        ID_EX_MR;
    logic        ID_EX_RW;
    logic [4:0]  ID_EX_DA;
    logic        EX_MEM_MR;
    logic [4:0]  EX_MEM_DA;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic        USE_B;
    logic        BR;
    logic        BR_TAKEN;
    logic        HALT;
    logic        MEM_BUSY;
    logic        PC_WE;
    logic        IF_ID_WE;
    logic        ID_EX_WE;
    logic        EX_MEM_WE;
    logic        MEM_WB_WE;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
    logic        HALTED;
    logic [15:0] STALL_CNT;

    modport master (
        output ID_EX_MR, ID_EX_RW, ID_EX_DA, EX_MEM_MR, EX_MEM_DA,
               AA, BA, USE_B, BR, BR_TAKEN, HALT, MEM_BUSY,
        input  PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE,
               IF_ID_FLUSH, ID_EX_FLUSH, HALTED, STALL_CNT
    );

    modport slave (
        input  ID_EX_MR, ID_EX_RW, ID_EX_DA, EX_MEM_MR, EX_MEM_DA,
               AA, BA, USE_B, BR, BR_TAKEN, HALT, MEM_BUSY,
        output PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE,
               IF_ID_FLUSH, ID_EX_FLUSH, HALTED, STALL_CNT
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use/branch stalls, branch flush, HALT drain.
// Define HAZARD_PERF_CNT_EN to build the saturating STALL_CNT counter; otherwise it reads 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; stalls/flushes from hazard detection
// ST_DRAIN | HALT in flight; fetch frozen while older instructions retire
// ST_HALTED| pipeline empty and stopped; only rst leaves
module hazard_control_unit (
    input  logic clk,
    input  logic rst,
    hazard_control_unit_if.slave hcu
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t     state;
    logic [1:0] drain_cnt;

    logic lu_hazard;
    logic bh_hazard;
    logic stall;
    logic pc_we;

    assign lu_hazard = hcu.ID_EX_MR && (hcu.ID_EX_DA != 5'd0) &&
                       ((hcu.ID_EX_DA == hcu.AA) ||
                        (hcu.USE_B && (hcu.ID_EX_DA == hcu.BA)));

    // A branch resolves in ID, so it waits for any producer still in EX or a load in MEM.
    assign bh_hazard = hcu.BR &&
                       ((hcu.ID_EX_RW && (hcu.ID_EX_DA != 5'd0) &&
                         ((hcu.ID_EX_DA == hcu.AA) || (hcu.ID_EX_DA == hcu.BA))) ||
                        (hcu.EX_MEM_MR && (hcu.EX_MEM_DA != 5'd0) &&
                         ((hcu.EX_MEM_DA == hcu.AA) || (hcu.EX_MEM_DA == hcu.BA))));

    assign stall = lu_hazard || bh_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!hcu.MEM_BUSY && !stall && hcu.HALT) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 2'd3;
                    end
                end
                ST_DRAIN: begin
                    if (!hcu.MEM_BUSY) begin
                        if (drain_cnt == 2'd1) begin
                            state     <= ST_HALTED;
                            drain_cnt <= 2'd0;
                        end else begin
                            drain_cnt <= drain_cnt - 2'd1;
                        end
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state     <= ST_RUN;
                    drain_cnt <= 2'd0;
                end
            endcase
        end
    end

    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic halted;

    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (!hcu.MEM_BUSY) begin
                        pc_we     = 1'b1;
                        if_id_we  = 1'b1;
                        id_ex_we  = 1'b1;
                        ex_mem_we = 1'b1;
                        mem_wb_we = 1'b1;
                        if (stall) begin
                            pc_we       = 1'b0;
                            if_id_we    = 1'b0;
                            id_ex_flush = 1'b1;
                        end else if (hcu.HALT) begin
                            // HALT moves on to EX; the slot behind it is squashed.
                            pc_we       = 1'b0;
                            if_id_flush = 1'b1;
                        end else if (hcu.BR_TAKEN) begin
                            if_id_flush = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!hcu.MEM_BUSY) begin
                        id_ex_we    = 1'b1;
                        ex_mem_we   = 1'b1;
                        mem_wb_we   = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    assign hcu.PC_WE       = pc_we;
    assign hcu.IF_ID_WE    = if_id_we;
    assign hcu.ID_EX_WE    = id_ex_we;
    assign hcu.EX_MEM_WE   = ex_mem_we;
    assign hcu.MEM_WB_WE   = mem_wb_we;
    assign hcu.IF_ID_FLUSH = if_id_flush;
    assign hcu.ID_EX_FLUSH = id_ex_flush;
    assign hcu.HALTED      = halted;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (((state == ST_RUN) || (state == ST_DRAIN)) && !pc_we &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign hcu.STALL_CNT = stall_cnt_q;
`else
    assign hcu.STALL_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
// Expected STALL_CNT values follow HAZARD_PERF_CNT_EN when it is defined for the build.
module tb_hazard_control_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hazard_control_unit_if hif ();

    hazard_control_unit dut (
        .clk (clk),
        .rst (rst),
        .hcu (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE, IF_ID_FLUSH, ID_EX_FLUSH, HALTED}
    localparam logic [7:0] V_RST    = 8'b00000_00_0;
    localparam logic [7:0] V_IDLE   = 8'b11111_00_0;
    localparam logic [7:0] V_STALL  = 8'b00111_01_0;
    localparam logic [7:0] V_FROZEN = 8'b00000_00_0;
    localparam logic [7:0] V_BRT    = 8'b11111_10_0;
    localparam logic [7:0] V_HALT   = 8'b01111_10_0;
    localparam logic [7:0] V_DRAIN  = 8'b00111_01_0;
    localparam logic [7:0] V_HLTD   = 8'b00000_00_1;

    function automatic logic [7:0] ctl();
        return {hif.PC_WE, hif.IF_ID_WE, hif.ID_EX_WE, hif.EX_MEM_WE, hif.MEM_WB_WE,
                hif.IF_ID_FLUSH, hif.ID_EX_FLUSH, hif.HALTED};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.ID_EX_MR  = 1'b0;
        hif.ID_EX_RW  = 1'b0;
        hif.ID_EX_DA  = 5'd0;
        hif.EX_MEM_MR = 1'b0;
        hif.EX_MEM_DA = 5'd0;
        hif.AA        = 5'd0;
        hif.BA        = 5'd0;
        hif.USE_B     = 1'b0;
        hif.BR        = 1'b0;
        hif.BR_TAKEN  = 1'b0;
        hif.HALT      = 1'b0;
        hif.MEM_BUSY  = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (ctl() !== V_RST) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", ctl(), V_RST);
        end
        n_cmp++;
        if (hif.STALL_CNT !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", hif.STALL_CNT);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL idle_run: got %b want %b", ctl(), V_IDLE);
        end
        tick();
    endtask

    task automatic test_load_use();
        pulse_reset();
        hif.ID_EX_MR = 1'b1; hif.ID_EX_RW = 1'b1; hif.ID_EX_DA = 5'd5; hif.AA = 5'd5;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL lu_stall: got %b want %b", ctl(), V_STALL);
        end
        tick();
        // load has moved to MEM, consumer not a branch -> no further stall
        clear_inputs();
        hif.EX_MEM_MR = 1'b1; hif.EX_MEM_DA = 5'd5; hif.AA = 5'd5;
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL lu_release: got %b want %b", ctl(), V_IDLE);
        end
        tick();
        clear_inputs();
        hif.ID_EX_MR = 1'b1; hif.ID_EX_DA = 5'd0; hif.AA = 5'd0;
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL lu_r0: got %b want %b", ctl(), V_IDLE);
        end
        tick();
        hif.ID_EX_DA = 5'd9; hif.AA = 5'd1; hif.BA = 5'd9; hif.USE_B = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL lu_b_used: got %b want %b", ctl(), V_STALL);
        end
        tick();
        hif.USE_B = 1'b0;
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL lu_b_unused: got %b want %b", ctl(), V_IDLE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_branch();
        pulse_reset();
        hif.BR = 1'b1; hif.AA = 5'd7;
        hif.ID_EX_MR = 1'b1; hif.ID_EX_RW = 1'b1; hif.ID_EX_DA = 5'd7;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL lb_stall1: got %b want %b", ctl(), V_STALL);
        end
        tick();
        hif.ID_EX_MR = 1'b0; hif.ID_EX_RW = 1'b0; hif.ID_EX_DA = 5'd0;
        hif.EX_MEM_MR = 1'b1; hif.EX_MEM_DA = 5'd7;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL lb_stall2: got %b want %b", ctl(), V_STALL);
        end
        tick();
        hif.EX_MEM_MR = 1'b0; hif.EX_MEM_DA = 5'd0; hif.BR_TAKEN = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_BRT) begin
            n_err++; $display("FAIL lb_taken: got %b want %b", ctl(), V_BRT);
        end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL lb_after: got %b want %b", ctl(), V_IDLE);
        end
        tick();
        // ALU producer in EX feeding a branch on BA
        hif.BR = 1'b1; hif.ID_EX_RW = 1'b1; hif.ID_EX_DA = 5'd12; hif.BA = 5'd12; hif.BR_TAKEN = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL bh_alu: got %b want %b", ctl(), V_STALL);
        end
        tick();
        hif.BR = 1'b0; hif.BR_TAKEN = 1'b0;
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL bh_nobranch: got %b want %b", ctl(), V_IDLE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_busy();
        pulse_reset();
        hif.ID_EX_MR = 1'b1; hif.ID_EX_DA = 5'd5; hif.AA = 5'd5;
        hif.MEM_BUSY = 1'b1; hif.BR_TAKEN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ctl() !== V_FROZEN) begin
                n_err++; $display("FAIL busy_freeze%0d: got %b want %b", i, ctl(), V_FROZEN);
            end
            tick();
        end
        hif.MEM_BUSY = 1'b0; hif.BR_TAKEN = 1'b0;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL busy_then_stall: got %b want %b", ctl(), V_STALL);
        end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL busy_done: got %b want %b", ctl(), V_IDLE);
        end
        n_cmp++;
        if (hif.STALL_CNT !== (PERF ? 16'd5 : 16'd0)) begin
            n_err++; $display("FAIL busy_cnt: got %0d want %0d", hif.STALL_CNT, PERF ? 5 : 0);
        end
        tick();
        // a stall outranks HALT: no drain starts
        hif.ID_EX_MR = 1'b1; hif.ID_EX_DA = 5'd3; hif.AA = 5'd3; hif.HALT = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL stall_over_halt: got %b want %b", ctl(), V_STALL);
        end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL stall_halt_run: got %b want %b", ctl(), V_IDLE);
        end
        tick();
    endtask

    task automatic test_halt();
        pulse_reset();
        hif.HALT = 1'b1; hif.BR_TAKEN = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_HALT) begin
            n_err++; $display("FAIL halt_issue: got %b want %b", ctl(), V_HALT);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ctl() !== V_DRAIN) begin
                n_err++; $display("FAIL drain%0d: got %b want %b", i, ctl(), V_DRAIN);
            end
            tick();
        end
        hif.BR_TAKEN = 1'b1; hif.HALT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ctl() !== V_HLTD) begin
                n_err++; $display("FAIL halted%0d: got %b want %b", i, ctl(), V_HLTD);
            end
            tick();
        end
        clear_inputs();
        n_cmp++;
        if (hif.STALL_CNT !== (PERF ? 16'd4 : 16'd0)) begin
            n_err++; $display("FAIL halt_cnt: got %0d want %0d", hif.STALL_CNT, PERF ? 4 : 0);
        end
        // busy cycles during drain stretch it
        pulse_reset();
        hif.HALT = 1'b1;
        tick();
        hif.HALT = 1'b0;
        #1;
        n_cmp++;
        if (ctl() !== V_DRAIN) begin
            n_err++; $display("FAIL bdrain_first: got %b want %b", ctl(), V_DRAIN);
        end
        tick();
        hif.MEM_BUSY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (ctl() !== V_FROZEN) begin
                n_err++; $display("FAIL bdrain_busy%0d: got %b want %b", i, ctl(), V_FROZEN);
            end
            tick();
        end
        hif.MEM_BUSY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (ctl() !== V_DRAIN) begin
                n_err++; $display("FAIL bdrain_rest%0d: got %b want %b", i, ctl(), V_DRAIN);
            end
            tick();
        end
        hif.MEM_BUSY = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_HLTD) begin
            n_err++; $display("FAIL bdrain_halted: got %b want %b", ctl(), V_HLTD);
        end
        n_cmp++;
        if (hif.STALL_CNT !== (PERF ? 16'd6 : 16'd0)) begin
            n_err++; $display("FAIL bdrain_cnt: got %0d want %0d", hif.STALL_CNT, PERF ? 6 : 0);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        // currently HALTED
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_RST) begin
            n_err++; $display("FAIL rst_in_halted: got %b want %b", ctl(), V_RST);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl() !== V_IDLE) begin
            n_err++; $display("FAIL run_after_halted: got %b want %b", ctl(), V_IDLE);
        end
        tick();
        hif.HALT = 1'b1;
        tick();
        hif.HALT = 1'b0;
        tick();
        // drain counter is now 2
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl() !== V_RST) begin
            n_err++; $display("FAIL rst_in_drain: got %b want %b", ctl(), V_RST);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (ctl() !== V_IDLE) begin
                n_err++; $display("FAIL run_after_drain%0d: got %b want %b", i, ctl(), V_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        hif.ID_EX_MR = 1'b1; hif.ID_EX_DA = 5'd4; hif.AA = 5'd4;
        repeat (100) tick();
        n_cmp++;
        if (hif.STALL_CNT !== (PERF ? 16'd100 : 16'd0)) begin
            n_err++; $display("FAIL cnt_100: got %0d want %0d", hif.STALL_CNT, PERF ? 100 : 0);
        end
        repeat (69900) tick();
        n_cmp++;
        if (hif.STALL_CNT !== (PERF ? 16'hFFFF : 16'd0)) begin
            n_err++; $display("FAIL cnt_sat: got %h want %h", hif.STALL_CNT, PERF ? 16'hFFFF : 16'h0);
        end
        n_cmp++;
        if (ctl() !== V_STALL) begin
            n_err++; $display("FAIL sat_stall: got %b want %b", ctl(), V_STALL);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_branch();
        test_mem_busy();
        test_halt();
        test_reset_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in, rst in.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ID_EX_MR  input  1  load instruction in EX.
REQ-005 ID_EX_RW  input  1  EX instruction writes a register.
REQ-006 ID_EX_DA  input  5  EX destination register.
REQ-007 EX_MEM_MR  input  1  load instruction in MEM.
REQ-008 EX_MEM_DA  input  5  MEM destination register.
REQ-009 AA, BA  input  5 each  ID source registers.
REQ-010 USE_B  input  1  ID instruction reads BA.
REQ-011 BR  input  1  ID instruction is a branch or jump.
REQ-012 BR_TAKEN  input  1  branch in ID resolved taken (valid only when not stalled).
REQ-013 HALT  input  1  ID instruction is HALT.
REQ-014 MEM_BUSY  input  1  data memory not ready.
REQ-015 PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE  output  1 each  pipeline register enables.
REQ-016 IF_ID_FLUSH, ID_EX_FLUSH  output  1 each  insert bubble into the register.
REQ-017 HALTED  output  1  pipeline drained and stopped.
REQ-018 STALL_CNT  output  16  stall-cycle counter.

Function
REQ-019 States SHALL be RUN, DRAIN, HALTED; outputs are combinational from state and inputs; all transitions occur on rising clk.
REQ-020 Load-use hazard (LU) SHALL be: ID_EX_MR=1, ID_EX_DA!=0, and ID_EX_DA==AA or (USE_B=1 and ID_EX_DA==BA).
REQ-021 Branch hazard (BH) SHALL be: BR=1 and either (ID_EX_RW=1, ID_EX_DA!=0, ID_EX_DA matches AA or BA) or (EX_MEM_MR=1, EX_MEM_DA!=0, EX_MEM_DA matches AA or BA).
REQ-022 Priority SHALL be: MEM_BUSY > LU/BH > HALT > BR_TAKEN.
REQ-023 MEM_BUSY=1 (any state except HALTED) SHALL drive all five WE=0 and both flushes=0; the state and drain counter hold.
REQ-024 RUN with LU or BH SHALL drive PC_WE=0, IF_ID_WE=0, ID_EX_FLUSH=1, with the other WE=1; the condition is re-evaluated every cycle, so a load feeding a branch gives exactly 2 stall cycles.
REQ-025 RUN with BR_TAKEN and no stall SHALL drive IF_ID_FLUSH=1 with all WE=1, for 1 cycle.
REQ-026 RUN with HALT and no stall SHALL drive PC_WE=0 and IF_ID_FLUSH=1 (HALT advances to EX), load the drain counter to 3, and go to DRAIN; BR_TAKEN is ignored that cycle.
REQ-027 DRAIN SHALL drive PC_WE=0, IF_ID_WE=0, ID_EX_FLUSH=1, with the other WE=1; the counter decrements on each non-busy cycle and the state goes to HALTED on the cycle it is 1.
REQ-028 HALTED SHALL drive all WE=0, both flushes=0, HALTED=1, and leave only on rst.
REQ-029 Idle RUN (no hazard) SHALL drive all WE=1, both flushes=0, HALTED=0.

Reset
REQ-030 rst=1 SHALL set the state to RUN, the drain counter to 0 and STALL_CNT to 0, and force all WE=0, both flushes=0 and HALTED=0 during that cycle.
REQ-031 rst asserted in DRAIN or HALTED SHALL abort the drain; RUN behaviour resumes on the first cycle after rst deasserts.

Configuration
REQ-032 With HAZARD_PERF_CNT_EN defined, STALL_CNT SHALL increment by 1 on each non-reset cycle where PC_WE=0 in state RUN or DRAIN, and SHALL saturate at 16'hFFFF.
REQ-033 Without HAZARD_PERF_CNT_EN, STALL_CNT SHALL be constant 0, the port SHALL remain, and no counter flops SHALL exist.

Verification
REQ-034 Load-use: ID_EX_MR=1, ID_EX_DA=5, AA=5 -> 1 cycle with PC_WE=0, IF_ID_WE=0, ID_EX_FLUSH=1; with ID_EX_DA=0 instead -> no stall.
REQ-035 Load then branch: BR=1, AA=7, load to x7 entering EX -> exactly 2 stall cycles (EX, then MEM match), then BR_TAKEN=1 -> IF_ID_FLUSH=1 for 1 cycle.
REQ-036 MEM_BUSY held 4 cycles during a load-use stall -> all WE=0 and flushes=0 for 4 cycles, then the 1-cycle stall completes; with HAZARD_PERF_CNT_EN defined, STALL_CNT=5.
REQ-037 HALT in RUN -> DRAIN for 3 cycles, HALTED=1 on cycle 4 and held; a MEM_BUSY pulse during DRAIN extends the drain by that many cycles.
REQ-038 rst pulsed in HALTED, and separately in DRAIN with counter=2 -> the next cycle is RUN with all WE=1 and HALTED=0.
REQ-039 Saturation: with HAZARD_PERF_CNT_EN defined, force 70000 stall cycles -> STALL_CNT=16'hFFFF; without HAZARD_PERF_CNT_EN -> STALL_CNT=0.
